// File: rtl/lzd_shift_count_controller.sv
// Shift-count controller: latches an LZD amount on start and emits one shift_en per counted cycle, then pulses done.
// Optional COMPARE_LE_EN macro switches the compare to counter <= target (one extra shift step).
module lzd_shift_count_controller #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             hold,
  input  logic [WIDTH-1:0] lzd_output,
  output logic [WIDTH-1:0] counter,
  output logic             is_less,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH:0]   r_cnt;
  logic [WIDTH-1:0] r_target;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH:0]   w_target_ext;
  logic             w_cmp;

  // One extra count bit keeps cnt from wrapping when target is all ones.
  assign w_target_ext = {1'b0, r_target};

`ifdef COMPARE_LE_EN
  assign w_cmp = (r_cnt <= w_target_ext);
`else
  assign w_cmp = (r_cnt < w_target_ext);
`endif

  assign is_less  = (r_state == S_COUNT) && w_cmp;
  assign shift_en = is_less && !hold;
  assign counter  = r_cnt[WIDTH-1:0];
  assign busy     = r_busy;
  assign done     = r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_target <= lzd_output;
            r_cnt    <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (w_cmp) begin
            if (!hold) begin
              r_cnt <= r_cnt + 1'b1;
            end
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lzd_shift_count_controller.sv
// Directed bench for lzd_shift_count_controller: pulse counts, done timing, hold, ignored start, reset.
module tb_lzd_shift_count_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       hold = 1'b0;
  logic [3:0] lzd_output = 4'd0;
  logic [3:0] counter;
  logic       is_less;
  logic       shift_en;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  lzd_shift_count_controller #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .hold       (hold),
    .lzd_output (lzd_output),
    .counter    (counter),
    .is_less    (is_less),
    .shift_en   (shift_en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Runs one operation; start accepted at the posedge ending cycle 0, sampling happens at negedges.
  task automatic run_case(input string name, input logic [3:0] t, input int hs, input int hl,
                          input bit poke_start, input int exp_pulses, input int exp_done,
                          input logic [3:0] exp_final);
    int cyc;
    int pulses;
    int done_cyc;
    @(negedge clk);
    lzd_output = t;
    start = 1'b1;
    hold = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    pulses = 0;
    done_cyc = 0;
    while (done_cyc == 0 && cyc < 80) begin
      hold = (cyc >= hs) && (cyc < hs + hl);
      if (poke_start) begin
        start = (cyc <= 2);
        lzd_output = 4'd9;
      end
      #1;
      if (done) begin
        done_cyc = cyc;
      end else begin
        chk({name, "_busy"}, busy, 1);
        chk({name, "_cnt"}, counter, pulses[3:0]);
        if (hold) chk({name, "_hold_shift"}, shift_en, 0);
        if (shift_en) begin
          chk({name, "_isless"}, is_less, 1);
          pulses++;
        end
        @(negedge clk);
        cyc++;
      end
    end
    hold = 1'b0;
    start = 1'b0;
    chk({name, "_done_cycle"}, done_cyc, exp_done);
    chk({name, "_pulses"}, pulses, exp_pulses);
    chk({name, "_final_cnt"}, counter, exp_final);
    chk({name, "_done_isless"}, is_less, 0);
    chk({name, "_done_busy"}, busy, 1);
    // A start during the DONE cycle must be ignored.
    lzd_output = t;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk({name, "_post_busy"}, busy, 0);
    chk({name, "_post_done"}, done, 0);
    $display("case %s: T=%0d pulses=%0d done_cycle=%0d", name, t, pulses, done_cyc);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk("reset_outputs", {counter, is_less, shift_en, busy, done}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_busy", busy, 0);
    end
    $display("reset: outputs cleared, idle for 5 cycles");

`ifdef COMPARE_LE_EN
    run_case("t7",    4'd7,  0, 0, 1'b0, 8,  10, 4'd8);
    run_case("t0",    4'd0,  0, 0, 1'b0, 1,  3,  4'd1);
    run_case("t15",   4'd15, 0, 0, 1'b0, 16, 18, 4'd0);
    run_case("hold5", 4'd5,  3, 3, 1'b0, 6,  11, 4'd6);
    run_case("busy3", 4'd3,  0, 0, 1'b1, 4,  6,  4'd4);
`else
    run_case("t7",    4'd7,  0, 0, 1'b0, 7,  9,  4'd7);
    run_case("t0",    4'd0,  0, 0, 1'b0, 0,  2,  4'd0);
    run_case("t15",   4'd15, 0, 0, 1'b0, 15, 17, 4'd15);
    run_case("hold5", 4'd5,  3, 3, 1'b0, 5,  10, 4'd5);
    run_case("busy3", 4'd3,  0, 0, 1'b1, 3,  5,  4'd3);
`endif

    // Reset in the middle of a count.
    @(negedge clk);
    lzd_output = 4'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rst_mid_cnt0", counter, 0);
    @(negedge clk);
    #1;
    chk("rst_mid_cnt1", counter, 1);
    chk("rst_mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {counter, is_less, shift_en, busy, done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_done", done, 0);
      chk("rst_no_busy", busy, 0);
    end
    $display("reset mid-count: outputs cleared, no done pulse");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
